alarm_ctrl: RTL
===============

# alarm_ctrl

Parametrised intruder-alarm controller and successor to the fixed 3-input alarm FSM. It monitors `N_ZONES` synchronous sensor inputs and supports two arming modes: away (all zones) and stay (perimeter zones only). It adds exit delay, per-zone entry delay, a timed siren and a latched record of tripped zones. It sits between the debounced sensor/keypad front end and the siren/indicator drivers.

## Interface
- `N_ZONES`, 3, number of sensor zones (≥1)
- `EXIT_CYC`, 8, cycles spent in EXIT after arming (≥1)
- `ENTRY_CYC`, 4, entry-delay cycles before a delayed zone raises the alarm (≥1)
- `ALARM_CYC`, 16, siren duration in cycles (≥1)
- `DELAY_MASK`, 1 (zone 0), zones that start entry delay instead of an instant alarm
- `PERIM_MASK`, 3 (zones 0,1), zones monitored in stay mode
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `x`  in  N_ZONES  zone sensors, 1 = tripped, already synchronous to `clk`
- `sel`  in  1  mode select, 0 = away, 1 = stay; sampled only on an accepted arm
- `arm`  in  1  arm request, level sampled each cycle
- `disarm`  in  1  disarm request, level sampled each cycle
- `y`  out  1  siren/alarm output
- `armed`  out  1  state ∈ {ARMED, ENTRY, ALARM}
- `pending`  out  1  state ∈ {EXIT, ENTRY}
- `zone_latch`  out  N_ZONES  zones that caused ENTRY/ALARM since last arm
- `state`  out  3  current state encoding, for debug

## Operation
- States: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4.
- `mon = x & (mode_q ? PERIM_MASK : all-ones)`, `inst = mon & ~DELAY_MASK`, `dly = mon & DELAY_MASK`.
- DISARMED:
  - `arm & ~disarm` → EXIT; `mode_q <= sel`, `zone_latch <= 0`, timer loaded `EXIT_CYC-1`.
  - Otherwise stay.
- EXIT:
  - Zones ignored.
  - `disarm` → DISARMED.
  - Timer==0 → ARMED; otherwise decrement.
- ARMED:
  - `disarm` → DISARMED.
  - Else `inst≠0` → ALARM; timer loaded `ALARM_CYC-1`.
  - Else `dly≠0` → ENTRY; timer loaded `ENTRY_CYC-1`.
  - `zone_latch |= mon` on either trip.
- ENTRY:
  - `disarm` → DISARMED.
  - Else `inst≠0` → ALARM immediately; timer reloaded `ALARM_CYC-1`.
  - Else timer==0 → ALARM; timer loaded `ALARM_CYC-1`.
  - Otherwise decrement.
  - `zone_latch |= mon` each cycle.
- ALARM:
  - `disarm` → DISARMED.
  - Else timer==0 → ARMED, which re-arms; a still-tripped zone re-triggers on the next cycle.
  - Otherwise decrement.
  - `zone_latch |= mon` each cycle.
- Priority in every state: `disarm` > zone events > timer expiry. `arm` is ignored outside DISARMED.
- `zone_latch` holds its value in DISARMED until the next accepted arm.
- Timer width is `$clog2(max(EXIT_CYC,ENTRY_CYC,ALARM_CYC))`, minimum 1. It saturates at 0 and never wraps.

## Timing
- Moore outputs, decoded from registered state. All request-to-output latency is 1 cycle.
- Reset values:
  - state = DISARMED; `y`, `armed`, `pending` = 0.
  - `zone_latch` = 0, `mode_q` = 0, timer = 0.
- Reset mid-operation, including during ALARM, returns to DISARMED asynchronously and drops `y` immediately.
- Dwell times, exact in absence of disarm or an instant zone:
  - EXIT: `EXIT_CYC` cycles.
  - ENTRY: `ENTRY_CYC` cycles.
  - ALARM: `ALARM_CYC` cycles with `y`=1.
- `arm` and `disarm` in the same cycle: `disarm` wins, state unchanged in DISARMED.
- Zone asserted in the same cycle EXIT expires: ignored; ARMED is entered and the zone is evaluated next cycle.

## Structure
- Package `alarm_pkg` holds:
  - state encoding localparams/enum (3-bit);
  - `max3` helper used to size the timer.
- One sub-module, `alarm_timer`: loadable down-counter with `load`, `load_val`, `dec`, `zero` outputs. It is shared across EXIT, ENTRY and ALARM.
- Next-state logic, mask logic and output decode stay in `alarm_ctrl`.

## Test plan
Defaults apply to all scenarios: N=3, EXIT=8, ENTRY=4, ALARM=16, DELAY_MASK=001, PERIM_MASK=011.
- **Away instant trip.** `arm` with `sel`=0 at cycle 0, then `x`=100 at cycle 10 → EXIT cycles 1–8, ARMED from 9. `y`=1 at cycle 11 for 16 cycles; `zone_latch`=100; back to ARMED at cycle 27.
- **Entry delay then disarm.** Armed away, `x`=001 pulse, `disarm` 2 cycles later → ENTRY with `pending`=1. Then DISARMED, `y` never asserts, `zone_latch`=001.
- **Entry expiry.** Armed, `x`=001 held → ENTRY for 4 cycles, then `y`=1. If `x`=010 arrives during ENTRY, ALARM starts the next cycle instead.
- **Stay mode masking.** `arm` with `sel`=1, `x`=100 after arming → no state change. `x`=010 → ALARM, `zone_latch`=010.
- **Exit window and priority.** `x`=111 during EXIT → ignored. `arm`&`disarm` together in DISARMED → stays DISARMED. `disarm` in ALARM → `y`=0 next cycle.
- **Async reset.** `rst` asserted mid-ALARM between clock edges → `y`, `armed`, `state` clear without a clock edge. After release, `arm` works normally.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared state encoding and sizing helper for the intruder-alarm controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter shared by the exit, entry and siren intervals.
module alarm_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Load beats decrement; decrement stops at zero instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alarm_ctrl.sv
// Intruder-alarm controller: away/stay arming, exit/entry delay, timed siren.
// state    | meaning
// DISARMED | idle, zone_latch holds last record
// EXIT     | exit delay, zones ignored
// ARMED    | watching monitored zones
// ENTRY    | delayed zone tripped, waiting for disarm
// ALARM    | siren on for ALARM_CYC cycles
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int          N_ZONES    = 3,
  parameter int          EXIT_CYC   = 8,
  parameter int          ENTRY_CYC  = 4,
  parameter int          ALARM_CYC  = 16,
  parameter int unsigned DELAY_MASK = 1,
  parameter int unsigned PERIM_MASK = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_ZONES-1:0] x,
  input  logic               sel,
  input  logic               arm,
  input  logic               disarm,
  output logic               y,
  output logic               armed,
  output logic               pending,
  output logic [N_ZONES-1:0] zone_latch,
  output logic [2:0]         state
);

  localparam int TMAX = max3(EXIT_CYC, ENTRY_CYC, ALARM_CYC);
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] EXIT_LD  = TW'(EXIT_CYC - 1);
  localparam logic [TW-1:0] ENTRY_LD = TW'(ENTRY_CYC - 1);
  localparam logic [TW-1:0] ALARM_LD = TW'(ALARM_CYC - 1);
  localparam logic [N_ZONES-1:0] DMASK = N_ZONES'(DELAY_MASK);
  localparam logic [N_ZONES-1:0] PMASK = N_ZONES'(PERIM_MASK);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [N_ZONES-1:0] zl_q, zl_d;
  logic [N_ZONES-1:0] mon, inst, dly;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]      tmr_val;

  assign mon  = x & (mode_q ? PMASK : {N_ZONES{1'b1}});
  assign inst = mon & ~DMASK;
  assign dly  = mon & DMASK;

  alarm_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_DISARMED;
      mode_q  <= 1'b0;
      zl_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      zl_q    <= zl_d;
    end
  end

  // disarm always wins; a disarm cycle does not add to the zone record
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    zl_d     = zl_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_DISARMED: begin
        if (arm && !disarm) begin
          state_d  = ST_EXIT;
          mode_d   = sel;
          zl_d     = '0;
          tmr_load = 1'b1;
          tmr_val  = EXIT_LD;
        end
      end
      ST_EXIT: begin
        if (disarm)        state_d = ST_DISARMED;
        else if (tmr_zero) state_d = ST_ARMED;
        else               tmr_dec = 1'b1;
      end
      ST_ARMED: begin
        if (disarm) begin
          state_d = ST_DISARMED;
        end else if (inst != '0) begin
          state_d  = ST_ALARM;
          tmr_load = 1'b1;
          tmr_val  = ALARM_LD;
          zl_d     = zl_q | mon;
        end else if (dly != '0) begin
          state_d  = ST_ENTRY;
          tmr_load = 1'b1;
          tmr_val  = ENTRY_LD;
          zl_d     = zl_q | mon;
        end
      end
      ST_ENTRY: begin
        if (disarm) begin
          state_d = ST_DISARMED;
        end else begin
          zl_d = zl_q | mon;
          if ((inst != '0) || tmr_zero) begin
            state_d  = ST_ALARM;
            tmr_load = 1'b1;
            tmr_val  = ALARM_LD;
          end else begin
            tmr_dec = 1'b1;
          end
        end
      end
      ST_ALARM: begin
        if (disarm) begin
          state_d = ST_DISARMED;
        end else begin
          zl_d = zl_q | mon;
          if (tmr_zero) state_d = ST_ARMED;
          else          tmr_dec = 1'b1;
        end
      end
      default: state_d = ST_DISARMED;
    endcase
  end

  assign y          = (state_q == ST_ALARM);
  assign armed      = (state_q == ST_ARMED) || (state_q == ST_ENTRY) || (state_q == ST_ALARM);
  assign pending    = (state_q == ST_EXIT) || (state_q == ST_ENTRY);
  assign zone_latch = zl_q;
  assign state      = state_q;

endmodule
